// File: rtl/ps2_key_pacer.sv
// PS/2 event queue that replays HPS key events to the keyboard matrix at a bounded rate.
// Optional typematic-repeat filter: define PS2_PACER_TYPEMATIC_FILTER_EN.
module ps2_key_pacer #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [23:0] GAP_CYCLES = 24'd500000
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [10:0]         ps2_key_in,
    output logic [10:0]         ps2_key_out,
    output logic                busy,
    output logic                overflow,
    output logic [DEPTH_LOG2:0] level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, GAP} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [23:0]           gap_cnt;
    logic                  prev_tog;
    logic [9:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_nxt;
    logic                  in_event;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;

    // Tracks the toggle even in reset so releasing reset never looks like an event.
    always_ff @(posedge clk_sys)
        prev_tog <= ps2_key_in[10];

    assign in_event = ps2_key_in[10] != prev_tog;
    assign full     = level == (DEPTH_LOG2+1)'(DEPTH);
    assign empty    = level == '0;
    assign pop      = (state == IDLE) && !empty;
    assign push     = push_req && (!full || pop);

`ifdef PS2_PACER_TYPEMATIC_FILTER_EN
    logic [511:0] held;
    logic [8:0]   key_idx;

    assign key_idx  = ps2_key_in[8:0];
    // Repeated makes of a key already down are swallowed before the FIFO.
    assign push_req = in_event && !(ps2_key_in[9] && held[key_idx]);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            held <= '0;
        end else if (in_event) begin
            if (!ps2_key_in[9])
                held[key_idx] <= 1'b0;
            else if (push)
                held[key_idx] <= 1'b1;
        end
    end
`else
    assign push_req = in_event;
`endif

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + (DEPTH_LOG2+1)'(1);
        else if (pop && !push)
            level_nxt = level - (DEPTH_LOG2+1)'(1);
        state_nxt = state;
        case (state)
            IDLE: if (pop) state_nxt = GAP;
            GAP:  if (gap_cnt == 24'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys)
        if (push)
            mem[wr_ptr] <= ps2_key_in[9:0];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            gap_cnt     <= 24'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            ps2_key_out <= 11'h000;
            busy        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            busy  <= (level_nxt != '0) || (state_nxt != IDLE);
            if (push)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (push_req && !push)
                overflow <= 1'b1;
            if (pop) begin
                ps2_key_out <= {~ps2_key_out[10], mem[rd_ptr]};
                rd_ptr      <= rd_ptr + DEPTH_LOG2'(1);
                gap_cnt     <= GAP_CYCLES - 24'd1;
            end else if (state == GAP && gap_cnt != 24'd0) begin
                gap_cnt <= gap_cnt - 24'd1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_pacer.sv
// Directed bench for ps2_key_pacer: two instances, short gap (4) and longer gap (30).
module tb_ps2_key_pacer;
    logic        clk_sys = 1'b0;
    logic        rst_a, rst_b;
    logic [10:0] in_a, in_b, out_a, out_b;
    logic        busy_a, busy_b, ovf_a, ovf_b;
    logic [4:0]  lvl_a, lvl_b;
    int          total = 0;
    int          bad = 0;
    int          tg_a = 0;
    int          tg_b = 0;
    logic        pa = 1'b0;
    logic        pb = 1'b0;

    always #5 clk_sys = ~clk_sys;

    ps2_key_pacer #(.DEPTH_LOG2(4), .GAP_CYCLES(24'd4)) dut_a (
        .clk_sys(clk_sys), .reset(rst_a), .ps2_key_in(in_a), .ps2_key_out(out_a),
        .busy(busy_a), .overflow(ovf_a), .level(lvl_a));

    ps2_key_pacer #(.DEPTH_LOG2(4), .GAP_CYCLES(24'd30)) dut_b (
        .clk_sys(clk_sys), .reset(rst_b), .ps2_key_in(in_b), .ps2_key_out(out_b),
        .busy(busy_b), .overflow(ovf_b), .level(lvl_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1ns later and count output toggles.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (out_a[10] !== pa) begin tg_a++; pa = out_a[10]; end
        if (out_b[10] !== pb) begin tg_b++; pb = out_b[10]; end
    endtask

    task automatic send_a(input logic pressed, input logic [7:0] code);
        in_a = {~in_a[10], pressed, 1'b0, code};
        tick();
    endtask

    task automatic send_b(input logic pressed, input logic [7:0] code);
        in_b = {~in_b[10], pressed, 1'b0, code};
        tick();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; in_a = 11'h000; in_b = 11'h000;
        repeat (3) tick();
        check("rst_out", 32'(out_a), 32'h000);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        check("rst_lvl", 32'(lvl_a), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        check("idle_lvl", 32'(lvl_a), 0);

        // Single event: written at t, emitted at t+1, busy clears at t+5
        send_a(1'b1, 8'h1c);
        check("single_lvl_t", 32'(lvl_a), 1);
        check("single_busy_t", 32'(busy_a), 1);
        check("single_out_t", 32'(out_a), 32'h000);
        tick();
        check("single_out_t1", 32'(out_a), 32'h61c);
        check("single_lvl_t1", 32'(lvl_a), 0);
        repeat (3) tick();
        check("single_busy_t4", 32'(busy_a), 1);
        tick();
        check("single_busy_t5", 32'(busy_a), 0);
        check("single_hold", 32'(out_a), 32'h61c);

        // Burst of three on consecutive cycles
        send_a(1'b1, 8'h1c);
        check("burst_lvl_e0", 32'(lvl_a), 1);
        send_a(1'b0, 8'h1c);
        check("burst_lvl_e1", 32'(lvl_a), 1);
        check("burst_out_e1", 32'(out_a), 32'h21c);
        send_a(1'b1, 8'h32);
        check("burst_lvl_e2", 32'(lvl_a), 2);
        repeat (3) tick();
        check("burst_out_e5", 32'(out_a), 32'h21c);
        tick();
        check("burst_out_e6", 32'(out_a), 32'h41c);
        check("burst_lvl_e6", 32'(lvl_a), 1);
        repeat (4) tick();
        check("burst_out_e10", 32'(out_a), 32'h41c);
        tick();
        check("burst_out_e11", 32'(out_a), 32'h232);
        check("burst_lvl_e11", 32'(lvl_a), 0);
        repeat (5) tick();
        check("burst_busy_end", 32'(busy_a), 0);

        // Typematic repeats of 0x1c followed by its break
        tg_a = 0;
        send_a(1'b1, 8'h1c);
        send_a(1'b1, 8'h1c);
        send_a(1'b1, 8'h1c);
        send_a(1'b0, 8'h1c);
        repeat (40) tick();
`ifdef PS2_PACER_TYPEMATIC_FILTER_EN
        check("typematic_count", 32'(tg_a), 2);
`else
        check("typematic_count", 32'(tg_a), 4);
`endif
        check("typematic_last", 32'(out_a), 32'h01c);
        check("typematic_busy", 32'(busy_a), 0);

        // Reset during GAP with five queued
        for (int i = 0; i < 6; i++) send_a(1'b1, 8'h40 + 8'(i));
        check("midrst_lvl_pre", 32'(lvl_a), 5);
        check("midrst_out_pre", 32'(out_a), 32'h640);
        rst_a = 1'b1;
        in_a[10] = ~in_a[10];
        tick();
        check("midrst_lvl", 32'(lvl_a), 0);
        check("midrst_out", 32'(out_a), 32'h000);
        check("midrst_busy", 32'(busy_a), 0);
        rst_a = 1'b0;
        tg_a = 0;
        repeat (10) tick();
        check("midrst_noevt_lvl", 32'(lvl_a), 0);
        check("midrst_noevt_busy", 32'(busy_a), 0);
        check("midrst_noevt_tog", 32'(tg_a), 0);

        // Overflow: 18 events back to back, gap 30
        tg_b = 0;
        for (int i = 0; i < 17; i++) send_b(1'b1, 8'(i));
        check("ovf_lvl_full", 32'(lvl_b), 16);
        check("ovf_pre", 32'(ovf_b), 0);
        send_b(1'b1, 8'h11);
        check("ovf_lvl_drop", 32'(lvl_b), 16);
        check("ovf_set", 32'(ovf_b), 1);
        repeat (600) tick();
        check("ovf_delivered", 32'(tg_b), 17);
        check("ovf_last_code", 32'(out_b[7:0]), 32'h10);
        check("ovf_sticky", 32'(ovf_b), 1);
        check("ovf_drained", 32'(lvl_b), 0);
        check("ovf_busy", 32'(busy_b), 0);

        // Full FIFO with push coinciding with the IDLE pop
        rst_b = 1'b1;
        tick();
        check("full_rst_ovf", 32'(ovf_b), 0);
        rst_b = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) send_b(1'b1, 8'h20 + 8'(i));
        check("full_lvl", 32'(lvl_b), 16);
        repeat (15) tick();
        check("full_lvl_e31", 32'(lvl_b), 16);
        check("full_out_e31", 32'(out_b[7:0]), 32'h20);
        send_b(1'b1, 8'h50);
        check("full_lvl_e32", 32'(lvl_b), 16);
        check("full_ovf_e32", 32'(ovf_b), 0);
        check("full_out_e32", 32'(out_b[7:0]), 32'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
